// File: rtl/brick_field_controller.sv
// Brick-field state keeper: loads a ROWS x COLS health grid from a level ROM,
// applies up to NUM_HITS collisions per clock, serves a registered pixel read
// port and tracks remaining destructible bricks.
module brick_field_controller #(
    parameter int unsigned ROWS     = 14,
    parameter int unsigned COLS     = 17,
    parameter int unsigned HP_W     = 3,
    parameter int unsigned NUM_HITS = 2,
    localparam int unsigned XW      = $clog2(COLS),
    localparam int unsigned YW      = $clog2(ROWS),
    localparam int unsigned AW      = $clog2(ROWS*COLS),
    localparam int unsigned CW      = $clog2(ROWS*COLS+1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_start,
    output logic [AW-1:0]          rom_addr,
    input  logic [HP_W-1:0]        rom_data,
    input  logic [NUM_HITS-1:0]    hit_valid,
    input  logic [NUM_HITS*XW-1:0] hit_x,
    input  logic [NUM_HITS*YW-1:0] hit_y,
    output logic [NUM_HITS-1:0]    hit_ack,
    output logic [NUM_HITS-1:0]    hit_destroyed,
    input  logic [XW-1:0]          rd_x,
    input  logic [YW-1:0]          rd_y,
    output logic [HP_W-1:0]        rd_hp,
    output logic                   busy,
    output logic [CW-1:0]          bricks_left,
    output logic                   level_clear
);

    localparam int unsigned NCELL = ROWS * COLS;
    localparam logic [HP_W-1:0] HP_MAX = '1;

    typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [HP_W-1:0]       r_cells [NCELL];
    logic [AW-1:0]         r_addr;
    logic [CW-1:0]         r_bricks;
    logic [NUM_HITS-1:0]   r_hit_ack;
    logic [NUM_HITS-1:0]   r_hit_dst;
    logic [HP_W-1:0]       r_rd_hp;
    logic                  r_busy;
    logic                  r_level_clear;

    logic                  w_ld_we;
    logic [AW-1:0]         w_ld_idx;
    logic                  w_ld_brick;
    logic                  w_hit_en;
    logic [NUM_HITS-1:0]   w_inr;
    logic [AW-1:0]         w_idx [NUM_HITS];
    logic [HP_W-1:0]       w_val [NUM_HITS];
    logic [NUM_HITS-1:0]   w_ack;
    logic [NUM_HITS-1:0]   w_dst;
    logic [CW-1:0]         w_kills;
    logic [CW-1:0]         w_bricks_nx;
    logic                  w_lc_nx;
    logic                  w_rd_inr;
    logic [AW-1:0]         w_rd_idx;

    assign rom_addr      = r_addr;
    assign hit_ack       = r_hit_ack;
    assign hit_destroyed = r_hit_dst;
    assign rd_hp         = r_rd_hp;
    assign busy          = r_busy;
    assign bricks_left   = r_bricks;
    assign level_clear   = r_level_clear;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_LOAD;
        else       r_state <= w_state_nx;
    end

    // Next-state logic: sweep ROM, drain the last word, then run until reload
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_LOAD:  if (r_addr == AW'(NCELL - 1)) w_state_nx = ST_DRAIN;
            ST_DRAIN: w_state_nx = ST_RUN;
            ST_RUN:   if (load_start) w_state_nx = ST_LOAD;
            default:  w_state_nx = ST_LOAD;
        endcase
    end

    // ROM write-back: data for address n arrives while address n+1 is issued
    always_comb begin
        w_ld_we    = ((r_state == ST_LOAD) && (r_addr != '0)) || (r_state == ST_DRAIN);
        w_ld_idx   = (r_state == ST_DRAIN) ? r_addr : r_addr - AW'(1);
        w_ld_brick = (rom_data != '0) && (rom_data != HP_MAX);
    end

    // Per-channel hit qualification; lowest channel wins on a shared cell
    always_comb begin
        logic dup;
        w_hit_en = (r_state == ST_RUN) && !load_start;
        w_ack    = '0;
        w_dst    = '0;
        w_kills  = '0;
        w_inr    = '0;
        for (int unsigned i = 0; i < NUM_HITS; i++) begin
            w_inr[i] = hit_valid[i] && (32'(hit_x[i*XW +: XW]) < COLS)
                                    && (32'(hit_y[i*YW +: YW]) < ROWS);
            w_idx[i] = w_inr[i] ? AW'(32'(hit_y[i*YW +: YW]) * COLS + 32'(hit_x[i*XW +: XW]))
                                : '0;
            w_val[i] = w_inr[i] ? r_cells[w_idx[i]] : '0;
            dup = 1'b0;
            for (int unsigned j = 0; j < i; j++) begin
                if (w_inr[j] && (w_idx[j] == w_idx[i])) dup = 1'b1;
            end
            w_ack[i] = w_hit_en && w_inr[i] && !dup &&
                       (w_val[i] != '0) && (w_val[i] != HP_MAX);
            w_dst[i] = w_ack[i] && (w_val[i] == HP_W'(1));
            w_kills  = w_kills + CW'(w_dst[i]);
        end
    end

    // Brick counter and level-clear qualification
    always_comb begin
        w_bricks_nx = r_bricks;
        w_lc_nx     = 1'b0;
        case (r_state)
            ST_LOAD, ST_DRAIN: begin
                if (w_ld_we && w_ld_brick) w_bricks_nx = r_bricks + CW'(1);
                if (r_state == ST_DRAIN && w_bricks_nx == '0) w_lc_nx = 1'b1;
            end
            ST_RUN: begin
                if (load_start)              w_bricks_nx = '0;
                else if (w_kills > r_bricks) w_bricks_nx = '0;
                else                         w_bricks_nx = r_bricks - w_kills;
                if (!load_start && r_bricks != '0 && w_bricks_nx == '0) w_lc_nx = 1'b1;
            end
            default: w_bricks_nx = r_bricks;
        endcase
    end

    // Read-port address decode
    always_comb begin
        w_rd_inr = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
        w_rd_idx = w_rd_inr ? AW'(32'(rd_y) * COLS + 32'(rd_x)) : '0;
    end

    // Datapath: grid, address counter, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NCELL; c++) r_cells[c] <= '0;
            r_addr        <= '0;
            r_bricks      <= '0;
            r_hit_ack     <= '0;
            r_hit_dst     <= '0;
            r_rd_hp       <= '0;
            r_busy        <= 1'b1;
            r_level_clear <= 1'b0;
        end else begin
            r_hit_ack     <= w_ack;
            r_hit_dst     <= w_dst;
            r_rd_hp       <= w_rd_inr ? r_cells[w_rd_idx] : '0;
            r_busy        <= (w_state_nx != ST_RUN);
            r_level_clear <= w_lc_nx;
            r_bricks      <= w_bricks_nx;
            if (w_ld_we) r_cells[w_ld_idx] <= rom_data;
            for (int unsigned i = 0; i < NUM_HITS; i++) begin
                if (w_ack[i]) r_cells[w_idx[i]] <= w_val[i] - HP_W'(1);
            end
            if (r_state == ST_LOAD && r_addr != AW'(NCELL - 1)) r_addr <= r_addr + AW'(1);
            else if (r_state == ST_RUN && load_start)           r_addr <= '0;
        end
    end

endmodule

// File: tb/tb_brick_field_controller.sv
// Directed bench for brick_field_controller using a registered level ROM model.
module tb_brick_field_controller;

    localparam int unsigned ROWS = 14;
    localparam int unsigned COLS = 17;
    localparam int unsigned HP_W = 3;
    localparam int unsigned NH   = 2;
    localparam int unsigned XW   = 5;
    localparam int unsigned YW   = 4;
    localparam int unsigned AW   = 8;
    localparam int unsigned CW   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 load_start;
    logic [AW-1:0]        rom_addr;
    logic [HP_W-1:0]      rom_data = '0;
    logic [NH-1:0]        hit_valid;
    logic [NH*XW-1:0]     hit_x;
    logic [NH*YW-1:0]     hit_y;
    logic [NH-1:0]        hit_ack;
    logic [NH-1:0]        hit_destroyed;
    logic [XW-1:0]        rd_x;
    logic [YW-1:0]        rd_y;
    logic [HP_W-1:0]      rd_hp;
    logic                 busy;
    logic [CW-1:0]        bricks_left;
    logic                 level_clear;

    int n_chk  = 0;
    int n_pass = 0;
    int img_sel = 0;
    int n;

    brick_field_controller dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
        .hit_ack(hit_ack), .hit_destroyed(hit_destroyed),
        .rd_x(rd_x), .rd_y(rd_y), .rd_hp(rd_hp),
        .busy(busy), .bricks_left(bricks_left), .level_clear(level_clear)
    );

    always #5 clk = ~clk;

    // Level images: 0 = (2,7)=3,(0,16)=1,(5,5)=7 ; 1 = (1,1)=1,(3,4)=1,(5,5)=7
    function automatic logic [HP_W-1:0] img(input int sel, input int idx);
        if (idx == 5*17+5) return 3'd7;
        if (sel == 0) begin
            if (idx == 2*17+7) return 3'd3;
            if (idx == 16)     return 3'd1;
        end else begin
            if (idx == 1*17+1) return 3'd1;
            if (idx == 3*17+4) return 3'd1;
        end
        return 3'd0;
    endfunction

    // Synchronous ROM: word for the address seen this cycle appears next cycle
    always @(posedge clk) rom_data <= img(img_sel, int'(rom_addr));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hits(input logic [1:0] v, input int x0, input int y0,
                           input int x1, input int y1);
        hit_valid = v;
        hit_x = {XW'(x1), XW'(x0)};
        hit_y = {YW'(y1), YW'(y0)};
        tick();
        hit_valid = '0;
    endtask

    task automatic rd(input int x, input int y, input int exp, input string tag);
        rd_x = XW'(x);
        rd_y = YW'(y);
        tick();
        chk(tag, 32'(rd_hp), exp);
    endtask

    task automatic wait_run(output int cnt);
        cnt = 0;
        while (busy && cnt < 400) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; hit_valid = '0; hit_x = '0; hit_y = '0;
        rd_x = '0; rd_y = '0;
        #3;
        chk("rst_busy", 32'(busy), 1);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_bricks", 32'(bricks_left), 0);
        chk("rst_lc", 32'(level_clear), 0);
        chk("rst_ack", 32'(hit_ack), 0);
        chk("rst_rd", 32'(rd_hp), 0);
        tick(); tick();
        reset = 1'b0;

        // Initial load
        wait_run(n);
        chk("load_cycles", n, 239);
        chk("load_bricks", 32'(bricks_left), 2);
        chk("load_lc", 32'(level_clear), 0);
        rd(7, 2, 3, "rd_2_7");
        rd(5, 5, 7, "rd_5_5");
        rd(16, 0, 1, "rd_0_16");
        rd(17, 0, 0, "rd_oor");

        // Decrement chain on (2,7)
        for (int k = 0; k < 3; k++) begin
            do_hits(2'b01, 7, 2, 0, 0);
            chk("chain_ack", 32'(hit_ack), 1);
            chk("chain_dst", 32'(hit_destroyed), (k == 2) ? 1 : 0);
            chk("chain_bricks", 32'(bricks_left), (k == 2) ? 1 : 2);
            rd(7, 2, 2 - k, "chain_cell");
            chk("chain_ack_idle", 32'(hit_ack), 0);
        end
        chk("chain_lc", 32'(level_clear), 0);

        // Indestructible, empty and out-of-range targets
        do_hits(2'b11, 5, 5, 3, 3);
        chk("solid_empty_ack", 32'(hit_ack), 0);
        do_hits(2'b11, 3, 14, 17, 0);
        chk("oor_ack", 32'(hit_ack), 0);
        rd(5, 5, 7, "solid_cell");
        chk("solid_bricks", 32'(bricks_left), 1);

        // Same-cell duplicate on (0,16)
        do_hits(2'b11, 16, 0, 16, 0);
        chk("dup_ack", 32'(hit_ack), 1);
        chk("dup_dst", 32'(hit_destroyed), 1);
        chk("dup_bricks", 32'(bricks_left), 0);
        chk("dup_lc", 32'(level_clear), 1);
        rd(16, 0, 0, "dup_cell");
        chk("dup_lc_once", 32'(level_clear), 0);

        // Reload with image 1
        img_sel = 1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("reload_busy", 32'(busy), 1);
        chk("reload_addr", 32'(rom_addr), 0);
        for (int k = 0; k < 5; k++) tick();
        chk("load_addr5", 32'(rom_addr), 5);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("ls_ignored", 32'(rom_addr), 6);
        wait_run(n);
        chk("reload_cycles", n, 233);
        chk("reload_bricks", 32'(bricks_left), 2);
        rd(1, 1, 1, "reload_1_1");
        rd(7, 2, 0, "reload_2_7");

        // Distinct simultaneous kills
        do_hits(2'b11, 1, 1, 4, 3);
        chk("kill2_ack", 32'(hit_ack), 3);
        chk("kill2_dst", 32'(hit_destroyed), 3);
        chk("kill2_bricks", 32'(bricks_left), 0);
        chk("kill2_lc", 32'(level_clear), 1);
        tick();
        chk("kill2_lc_once", 32'(level_clear), 0);

        // Reset abort mid-load
        img_sel = 0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        n = 0;
        while (rom_addr != 8'd100 && n < 300) begin
            tick();
            n++;
        end
        chk("reach_addr100", 32'(rom_addr), 100);
        chk("pre_abort_bricks", 32'(bricks_left), 2);
        #2 reset = 1'b1;
        #1;
        chk("abort_addr", 32'(rom_addr), 0);
        chk("abort_bricks", 32'(bricks_left), 0);
        chk("abort_busy", 32'(busy), 1);
        tick();
        reset = 1'b0;
        wait_run(n);
        chk("abort_reload_cycles", n, 239);
        chk("abort_reload_bricks", 32'(bricks_left), 2);
        rd(7, 2, 3, "abort_rd_2_7");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
